// File: rtl/fifo_n_entry.sv
// fifo_n_entry: multi-channel ingress FIFO.
// NUM_CH independent circular buffers feed one look-ahead output register.
// Arbitration is either max-occupancy or round-robin, selectable per cycle.
// Each channel reports a full flag, and HFULL flags any channel at or above
// HFULL_TH. DO_CH tags the channel that DO came from.
module fifo_n_entry #(
   parameter int DATA_SIZE     = 49,
   parameter int FIFO_SIZE     = 8,
   parameter int FIFO_ADDR_LEN = 3,
   parameter int NUM_CH        = 4,
   parameter int CH_ADDR_LEN   = 2,
   parameter int HFULL_TH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          DEQ,
   input  logic                          MODE,
   input  logic [NUM_CH-1:0]             ENQ,
   input  logic [NUM_CH*DATA_SIZE-1:0]   DI,
   output logic                          EMPTY,
   output logic                          FULL,
   output logic                          HFULL,
   output logic [NUM_CH-1:0]             CH_FULL,
   output logic [DATA_SIZE-1:0]          DO,
   output logic [CH_ADDR_LEN-1:0]        DO_CH
);

   localparam logic [FIFO_ADDR_LEN:0]   CNT_FULL = (FIFO_ADDR_LEN+1)'(FIFO_SIZE);
   localparam logic [FIFO_ADDR_LEN:0]   CNT_HALF = (FIFO_ADDR_LEN+1)'(HFULL_TH);
   localparam logic [FIFO_ADDR_LEN:0]   CNT_ONE  = (FIFO_ADDR_LEN+1)'(1);
   localparam logic [FIFO_ADDR_LEN-1:0] PTR_ONE  = FIFO_ADDR_LEN'(1);
   localparam logic [CH_ADDR_LEN-1:0]   RR_INIT  = CH_ADDR_LEN'(NUM_CH-1);
   localparam logic [NUM_CH-1:0]        CH_ONE   = NUM_CH'(1);

   // Per-channel views gathered from the generate blocks.
   logic [NUM_CH-1:0][FIFO_ADDR_LEN:0] count;
   logic [NUM_CH-1:0][DATA_SIZE-1:0]   head;
   logic [NUM_CH-1:0]                  nonzero;
   logic [NUM_CH-1:0]                  push;
   logic [NUM_CH-1:0]                  pop;
   logic [NUM_CH-1:0]                  half;

   // Output stage and arbitration state.
   logic                               empty_reg;
   logic [DATA_SIZE-1:0]               do_reg;
   logic [CH_ADDR_LEN-1:0]             do_ch_reg;
   logic [CH_ADDR_LEN-1:0]             rr_ptr_reg;

   // Arbitration results.
   logic                               ld;
   logic                               any_ready;
   logic [CH_ADDR_LEN-1:0]             sel_max;
   logic [CH_ADDR_LEN-1:0]             sel_rr;
   logic [CH_ADDR_LEN-1:0]             sel;
   logic [FIFO_ADDR_LEN:0]             best_cnt;
   logic                               rr_found;
   logic [CH_ADDR_LEN-1:0]             rr_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [DATA_SIZE-1:0]     mem [FIFO_SIZE];
         logic [FIFO_ADDR_LEN-1:0] wr_ptr_reg;
         logic [FIFO_ADDR_LEN-1:0] rd_ptr_reg;
         logic [FIFO_ADDR_LEN:0]   count_reg;

         // Full test uses the registered count, so a same-cycle pop never
         // lets a write into a full channel.
         assign CH_FULL[gi] = (count_reg == CNT_FULL);
         assign half[gi]    = (count_reg >= CNT_HALF);
         assign push[gi]    = ENQ[gi] & ~CH_FULL[gi];
         assign nonzero[gi] = |count_reg;
         assign count[gi]   = count_reg;
         assign head[gi]    = mem[rd_ptr_reg];

         // Payload storage; no reset so it maps onto plain RAM.
         always_ff @(posedge clk) begin
            if (push[gi]) begin
               mem[wr_ptr_reg] <= DI[gi*DATA_SIZE +: DATA_SIZE];
            end
         end

         // Pointers wrap naturally at FIFO_SIZE; count tracks push/pop.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (push[gi]) begin
                  wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
               end
               if (pop[gi]) begin
                  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
               end
               case ({push[gi], pop[gi]})
                  2'b10:   count_reg <= count_reg + CNT_ONE;
                  2'b01:   count_reg <= count_reg - CNT_ONE;
                  default: count_reg <= count_reg;
               endcase
            end
         end
      end
   endgenerate

   // Max-occupancy pick: strict greater-than keeps ties on the lowest index.
   always_comb begin
      sel_max  = '0;
      best_cnt = count[0];
      for (int i = 1; i < NUM_CH; i++) begin
         if (count[i] > best_cnt) begin
            best_cnt = count[i];
            sel_max  = CH_ADDR_LEN'(i);
         end
      end
   end

   // Round-robin pick: first nonempty channel after the last one served.
   always_comb begin
      sel_rr   = '0;
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         rr_idx = CH_ADDR_LEN'((int'(rr_ptr_reg) + k) % NUM_CH);
         if (!rr_found && nonzero[rr_idx]) begin
            rr_found = 1'b1;
            sel_rr   = rr_idx;
         end
      end
   end

   // Load decision and the one-hot pop toward the channel buffers.
   always_comb begin
      any_ready = |nonzero;
      sel       = MODE ? sel_rr : sel_max;
      ld        = empty_reg | DEQ;
      pop       = '0;
      if (ld && any_ready) begin
         pop = CH_ONE << sel;
      end
   end

   // Look-ahead output register: refilled whenever it is empty or consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         empty_reg  <= 1'b1;
         do_reg     <= '0;
         do_ch_reg  <= '0;
         rr_ptr_reg <= RR_INIT;
      end else if (ld) begin
         if (any_ready) begin
            do_reg     <= head[sel];
            do_ch_reg  <= sel;
            empty_reg  <= 1'b0;
            rr_ptr_reg <= sel;
         end else begin
            empty_reg  <= 1'b1;
         end
      end
   end

   assign EMPTY = empty_reg;
   assign DO    = do_reg;
   assign DO_CH = do_ch_reg;
   assign FULL  = |CH_FULL;
   assign HFULL = |half;

endmodule

// File: tb/tb_fifo_n_entry.sv
// Testbench for fifo_n_entry: directed vector table, corner-case sequences
// and randomized traffic checked against a queue-based reference model.
module tb_fifo_n_entry;

   localparam int DATA_SIZE = 49;
   localparam int FIFO_SIZE = 8;
   localparam int NUM_CH    = 4;
   localparam int HFULL_TH  = 4;

   typedef logic [DATA_SIZE-1:0] word_t;
   typedef logic [NUM_CH*DATA_SIZE-1:0] bus_t;

   typedef struct {
      logic [3:0] enq;
      logic       deq;
      logic       mode;
      word_t      word;
      logic       exp_empty;
      word_t      exp_do;
      logic [1:0] exp_ch;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        DEQ;
   logic        MODE;
   logic [3:0]  ENQ;
   bus_t        DI;
   logic        EMPTY;
   logic        FULL;
   logic        HFULL;
   logic [3:0]  CH_FULL;
   word_t       DO;
   logic [1:0]  DO_CH;

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;

   // Reference model state.
   word_t       mq [NUM_CH][$];
   logic        m_empty;
   word_t       m_do;
   logic [1:0]  m_ch;
   int          m_rr;

   vec_t        vecs [$];

   fifo_n_entry #(
      .DATA_SIZE(DATA_SIZE), .FIFO_SIZE(FIFO_SIZE), .FIFO_ADDR_LEN(3),
      .NUM_CH(NUM_CH), .CH_ADDR_LEN(2), .HFULL_TH(HFULL_TH)
   ) dut (
      .clk(clk), .rst(rst), .DEQ(DEQ), .MODE(MODE), .ENQ(ENQ), .DI(DI),
      .EMPTY(EMPTY), .FULL(FULL), .HFULL(HFULL), .CH_FULL(CH_FULL),
      .DO(DO), .DO_CH(DO_CH)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running required finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic bus_t dup(input word_t w);
      return {NUM_CH{w}};
   endfunction

   function automatic vec_t mk(input logic [3:0] e, input logic d, input logic m, input word_t w,
                               input logic xe, input word_t xd, input logic [1:0] xc);
      vec_t v;
      v.enq = e; v.deq = d; v.mode = m; v.word = w;
      v.exp_empty = xe; v.exp_do = xd; v.exp_ch = xc;
      return v;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      m_empty = 1'b1;
      m_do    = '0;
      m_ch    = '0;
      m_rr    = NUM_CH - 1;
   endtask

   // One clock edge of the behavioural model: choose, pop, then accept writes
   // against the occupancy seen before the edge.
   task automatic model_step(input logic [3:0] e, input logic d, input logic m, input bus_t di);
      int cnt [NUM_CH];
      int best;
      int s;
      bit any;
      for (int c = 0; c < NUM_CH; c++) cnt[c] = mq[c].size();
      if (m_empty || d) begin
         any = 0;
         s = 0;
         if (!m) begin
            best = 0;
            for (int c = 0; c < NUM_CH; c++) begin
               if (cnt[c] > best) begin best = cnt[c]; s = c; any = 1; end
            end
         end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
               int c;
               c = (m_rr + k) % NUM_CH;
               if (!any && cnt[c] > 0) begin any = 1; s = c; end
            end
         end
         if (any) begin
            m_do    = mq[s].pop_front();
            m_ch    = 2'(s);
            m_empty = 1'b0;
            m_rr    = s;
         end else begin
            m_empty = 1'b1;
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (e[c] && cnt[c] < FIFO_SIZE) mq[c].push_back(di[c*DATA_SIZE +: DATA_SIZE]);
      end
   endtask

   task automatic model_chk();
      logic [3:0] xf;
      logic       xh;
      xh = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         xf[c] = (mq[c].size() == FIFO_SIZE);
         if (mq[c].size() >= HFULL_TH) xh = 1'b1;
      end
      chk("model_empty",   64'(EMPTY),   64'(m_empty));
      chk("model_do",      64'(DO),      64'(m_do));
      chk("model_do_ch",   64'(DO_CH),   64'(m_ch));
      chk("model_ch_full", 64'(CH_FULL), 64'(xf));
      chk("model_full",    64'(FULL),    64'(|xf));
      chk("model_hfull",   64'(HFULL),   64'(xh));
   endtask

   // Apply one cycle of inputs, advance the model and compare after the edge.
   task automatic step(input logic [3:0] e, input logic d, input logic m, input bus_t di);
      ENQ  = e;
      DEQ  = d;
      MODE = m;
      DI   = di;
      @(posedge clk);
      model_step(e, d, m, di);
      #1;
      model_chk();
      n_txn++;
      $display("txn %0d enq=%b deq=%b mode=%b empty=%b do_ch=%0d do=%h full=%b hfull=%b",
               n_txn, e, d, m, EMPTY, DO_CH, DO, FULL, HFULL);
   endtask

   localparam word_t AB = 49'h1_0000_0000_00AB;
   localparam word_t W1 = 49'h0_0000_1000_0001;
   localparam word_t W2 = 49'h0_0000_1000_0002;
   localparam word_t W3 = 49'h0_0000_1000_0003;
   localparam word_t W4 = 49'h0_0000_1000_0004;
   localparam word_t WA = 49'h0_AAAA_0000_000A;
   localparam word_t WB = 49'h1_BBBB_0000_000B;

   initial begin
      word_t w;
      logic [63:0] r64;
      bus_t rdi;
      logic [3:0] re;
      logic rd;
      logic rm;

      rst = 1'b1; DEQ = 1'b0; MODE = 1'b0; ENQ = '0; DI = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      model_chk();
      chk("reset_empty", 64'(EMPTY), 64'(1));
      chk("reset_do", 64'(DO), 64'(0));
      #2 rst = 1'b0;

      // Directed vectors: single word, max-occupancy order, round-robin order.
      vecs.push_back(mk(4'b0100, 0, 0, AB, 1, '0, 2'd0));
      vecs.push_back(mk(4'b0000, 0, 0, AB, 0, AB, 2'd2));
      vecs.push_back(mk(4'b0000, 1, 0, AB, 1, AB, 2'd2));
      vecs.push_back(mk(4'b1010, 0, 0, W1, 1, AB, 2'd2));
      vecs.push_back(mk(4'b1010, 0, 0, W2, 0, W1, 2'd1));
      vecs.push_back(mk(4'b1010, 0, 0, W3, 0, W1, 2'd1));
      vecs.push_back(mk(4'b0001, 0, 0, W4, 0, W1, 2'd1));
      vecs.push_back(mk(4'b0000, 1, 0, W4, 0, W1, 2'd3));
      vecs.push_back(mk(4'b0000, 1, 0, W4, 0, W2, 2'd1));
      vecs.push_back(mk(4'b0000, 1, 0, W4, 0, W2, 2'd3));
      vecs.push_back(mk(4'b0000, 1, 0, W4, 0, W4, 2'd0));
      vecs.push_back(mk(4'b0000, 1, 0, W4, 0, W3, 2'd1));
      vecs.push_back(mk(4'b0000, 1, 0, W4, 0, W3, 2'd3));
      vecs.push_back(mk(4'b0000, 1, 0, W4, 1, W3, 2'd3));
      vecs.push_back(mk(4'b1111, 0, 1, WA, 1, W3, 2'd3));
      vecs.push_back(mk(4'b1111, 0, 1, WB, 0, WA, 2'd0));
      vecs.push_back(mk(4'b0000, 1, 1, WB, 0, WA, 2'd1));
      vecs.push_back(mk(4'b0000, 1, 1, WB, 0, WA, 2'd2));
      vecs.push_back(mk(4'b0000, 1, 1, WB, 0, WA, 2'd3));
      vecs.push_back(mk(4'b0000, 1, 1, WB, 0, WB, 2'd0));
      vecs.push_back(mk(4'b0000, 1, 1, WB, 0, WB, 2'd1));
      vecs.push_back(mk(4'b0000, 1, 1, WB, 0, WB, 2'd2));
      vecs.push_back(mk(4'b0000, 1, 1, WB, 0, WB, 2'd3));
      vecs.push_back(mk(4'b0000, 1, 1, WB, 1, WB, 2'd3));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].enq, vecs[i].deq, vecs[i].mode, dup(vecs[i].word));
         chk($sformatf("vec%0d_empty", i), 64'(EMPTY), 64'(vecs[i].exp_empty));
         chk($sformatf("vec%0d_do", i),    64'(DO),    64'(vecs[i].exp_do));
         chk($sformatf("vec%0d_do_ch", i), 64'(DO_CH), 64'(vecs[i].exp_ch));
      end

      // Fill channel 0: one word sits in DO, eight more reach the full mark.
      for (int k = 0; k < 9; k++) begin
         w = 49'h0_F000_0000_0000 | word_t'(k);
         step(4'b0001, 0, 0, dup(w));
         if (k == 3) chk("fill_hfull_below", 64'(HFULL), 64'(0));
         if (k == 4) chk("fill_hfull_at_th", 64'(HFULL), 64'(1));
      end
      chk("fill_ch_full", 64'(CH_FULL), 64'(4'b0001));
      chk("fill_full", 64'(FULL), 64'(1));
      step(4'b0001, 0, 0, dup(49'h0_F000_0000_0009));
      chk("fill_drop_ch_full", 64'(CH_FULL), 64'(4'b0001));
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("drain0_word%0d", k), 64'(DO), 64'(49'h0_F000_0000_0000 | word_t'(k)));
         chk($sformatf("drain0_ch%0d", k), 64'(DO_CH), 64'(0));
         step(4'b0000, 1, 0, '0);
      end
      chk("drain0_empty", 64'(EMPTY), 64'(1));

      // Channel 1 full: pop and write in the same cycle; the write is dropped.
      for (int k = 0; k < 9; k++) step(4'b0010, 0, 0, dup(49'h0_6000_0000_0000 | word_t'(k)));
      chk("ch1_full_before", 64'(CH_FULL), 64'(4'b0010));
      step(4'b0010, 1, 0, dup(49'h1_DEAD_0000_BEEF));
      chk("ch1_popword", 64'(DO), 64'(49'h0_6000_0000_0001));
      chk("ch1_not_full_after", 64'(CH_FULL), 64'(4'b0000));
      for (int k = 1; k < 9; k++) begin
         chk($sformatf("drain1_word%0d", k), 64'(DO), 64'(49'h0_6000_0000_0000 | word_t'(k)));
         step(4'b0000, 1, 0, '0);
      end
      chk("drain1_empty", 64'(EMPTY), 64'(1));

      // Channel 2 at count 3: simultaneous write and pop keeps the count.
      for (int k = 0; k < 4; k++) step(4'b0100, 0, 0, dup(49'h0_7000_0000_0000 | word_t'(k)));
      chk("ch2_cnt3_hfull", 64'(HFULL), 64'(0));
      step(4'b0100, 1, 0, dup(49'h0_7000_0000_0004));
      chk("ch2_swap_do", 64'(DO), 64'(49'h0_7000_0000_0001));
      chk("ch2_swap_hfull", 64'(HFULL), 64'(0));
      step(4'b0100, 0, 0, dup(49'h0_7000_0000_0005));
      chk("ch2_cnt4_hfull", 64'(HFULL), 64'(1));
      for (int k = 2; k < 6; k++) begin
         step(4'b0000, 1, 0, '0);
         chk($sformatf("drain2_word%0d", k), 64'(DO), 64'(49'h0_7000_0000_0000 | word_t'(k)));
      end
      step(4'b0000, 1, 0, '0);
      chk("drain2_empty", 64'(EMPTY), 64'(1));

      // Reset pulse mid-stream with five words buffered behind DO.
      for (int k = 0; k < 6; k++) step(4'b1000, 0, 0, dup(49'h0_8000_0000_0000 | word_t'(k)));
      chk("pre_rst_empty", 64'(EMPTY), 64'(0));
      #3 rst = 1'b1;
      model_reset();
      #1;
      model_chk();
      chk("rst_mid_empty", 64'(EMPTY), 64'(1));
      chk("rst_mid_do", 64'(DO), 64'(0));
      chk("rst_mid_do_ch", 64'(DO_CH), 64'(0));
      chk("rst_mid_ch_full", 64'(CH_FULL), 64'(0));
      chk("rst_mid_hfull", 64'(HFULL), 64'(0));
      #1 rst = 1'b0;
      step(4'b0100, 0, 0, dup(AB));
      chk("post_rst_lat1", 64'(EMPTY), 64'(1));
      step(4'b0000, 0, 0, '0);
      chk("post_rst_lat2_empty", 64'(EMPTY), 64'(0));
      chk("post_rst_lat2_do", 64'(DO), 64'(AB));
      chk("post_rst_lat2_ch", 64'(DO_CH), 64'(2));

      // Randomized traffic against the reference model.
      rm = 1'b0;
      for (int n = 0; n < 1200; n++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            re[c] = ($urandom_range(0, 99) < 45);
            r64 = {$urandom, $urandom};
            rdi[c*DATA_SIZE +: DATA_SIZE] = r64[DATA_SIZE-1:0];
         end
         rd = ($urandom_range(0, 99) < 40);
         if ($urandom_range(0, 99) < 5) rm = ~rm;
         step(re, rd, rm, rdi);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
